// File: rtl/dbi_frame_writer_pkg.sv
// Shared definitions for the DBI frame AXI writer.
//   wr_state_e    : writer FSM states (IDLE / AW / W / B)
//   AXI_RESP_OKAY : BRESP value treated as success
//   burst_len()   : beats in the next burst, min(remaining, max_burst)
package dbi_frame_writer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_AW   = 2'd1,
    ST_W    = 2'd2,
    ST_B    = 2'd3
  } wr_state_e;

  localparam logic [1:0] AXI_RESP_OKAY = 2'b00;

  function automatic int unsigned burst_len(input int unsigned remaining,
                                            input int unsigned max_burst);
    return (remaining < max_burst) ? remaining : max_burst;
  endfunction

endpackage

// File: rtl/axi_skid_buf.sv
// Two-entry valid/ready register slice (skid buffer).
//   clk, rst     : clock, synchronous active-high reset
//   in_*         : upstream side; in_ready_o is registered (low only when the
//                  skid entry is occupied)
//   out_*        : downstream side; out_data_o/out_valid_o come straight from
//                  a register and hold until out_ready_i
module axi_skid_buf #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  output logic [WIDTH-1:0] out_data_o,
  output logic             out_valid_o,
  input  logic             out_ready_i
);

  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] skid_data_q, skid_data_d;
  logic             skid_valid_q, skid_valid_d;
  logic             accept;

  assign in_ready_o  = ~skid_valid_q;
  assign accept      = in_valid_i & ~skid_valid_q;
  assign out_data_o  = out_data_q;
  assign out_valid_o = out_valid_q;

  always_comb begin
    out_data_d   = out_data_q;
    out_valid_d  = out_valid_q;
    skid_data_d  = skid_data_q;
    skid_valid_d = skid_valid_q;
    if (out_ready_i || !out_valid_q) begin
      // Output register free this cycle: drain skid first, else take input.
      if (skid_valid_q) begin
        out_data_d   = skid_data_q;
        out_valid_d  = 1'b1;
        skid_valid_d = 1'b0;
      end else begin
        out_valid_d = accept;
        if (accept) out_data_d = in_data_i;
      end
    end else if (accept) begin
      // Output stalled: park the word so in_ready can stay registered.
      skid_data_d  = in_data_i;
      skid_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_data_q   <= '0;
      out_valid_q  <= 1'b0;
      skid_data_q  <= '0;
      skid_valid_q <= 1'b0;
    end else begin
      out_data_q   <= out_data_d;
      out_valid_q  <= out_valid_d;
      skid_data_q  <= skid_data_d;
      skid_valid_q <= skid_valid_d;
    end
  end

endmodule

// File: rtl/dbi_frame_axi_writer.sv
// Packs a stream of pixel words into AXI4 write bursts at a fixed address.
//   clk, rst          : clock, synchronous active-high reset
//   start_i           : start a frame of frame_beats_i words (IDLE only)
//   busy_o            : frame in progress
//   frame_done_o      : one-cycle pulse when the frame completes
//   resp_err_o        : sticky, a non-OKAY BRESP was seen in this frame
//   s_pix_*           : pixel word stream (valid/ready)
//   m_aw*/m_w*/m_b*   : AXI4 write address, data and response channels
module dbi_frame_axi_writer
  import dbi_frame_writer_pkg::*;
#(
  parameter int unsigned           DMA_DATA_W        = 256,
  parameter int unsigned           ADDR_W            = 32,
  parameter int unsigned           MST_ID_W          = 5,
  parameter int unsigned           TRANS_DATA_LEN_W  = 8,
  parameter int unsigned           TRANS_RESP_W      = 2,
  parameter logic [MST_ID_W-1:0]   MST_ID            = 5'h00,
  parameter logic [ADDR_W-1:0]     IP_DATA_BASE_ADDR = 32'h2000_0000,
  parameter int unsigned           MAX_BURST         = 16,
  parameter int unsigned           FRAME_BEATS_W     = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start_i,
  input  logic [FRAME_BEATS_W-1:0]    frame_beats_i,
  output logic                        busy_o,
  output logic                        frame_done_o,
  output logic                        resp_err_o,
  input  logic [DMA_DATA_W-1:0]       s_pix_data_i,
  input  logic                        s_pix_valid_i,
  output logic                        s_pix_ready_o,
  output logic [MST_ID_W-1:0]         m_awid_o,
  output logic [ADDR_W-1:0]           m_awaddr_o,
  output logic [TRANS_DATA_LEN_W-1:0] m_awlen_o,
  output logic                        m_awvalid_o,
  input  logic                        m_awready_i,
  output logic [DMA_DATA_W-1:0]       m_wdata_o,
  output logic                        m_wlast_o,
  output logic                        m_wvalid_o,
  input  logic                        m_wready_i,
  input  logic [MST_ID_W-1:0]         m_bid_i,
  input  logic [TRANS_RESP_W-1:0]     m_bresp_i,
  input  logic                        m_bvalid_i,
  output logic                        m_bready_o
);

  wr_state_e                state_q, state_d;
  logic [FRAME_BEATS_W-1:0] remaining_q, remaining_d;
  logic [FRAME_BEATS_W-1:0] burst_q, burst_d;
  logic [FRAME_BEATS_W-1:0] acc_cnt_q, acc_cnt_d;
  logic [FRAME_BEATS_W-1:0] remaining_after;
  logic                     resp_err_q, resp_err_d;
  logic                     frame_done_q, frame_done_d;

  logic                     pix_hs;
  logic                     w_hs;
  logic                     skid_in_ready;
  logic [DMA_DATA_W:0]      skid_in;
  logic [DMA_DATA_W:0]      skid_out;
  logic                     skid_out_valid;
  logic                     unused_bid;

  assign unused_bid = ^m_bid_i;

  // W path: {last, data}; last is tagged when the word is accepted so the
  // buffer needs no knowledge of burst boundaries.
  assign pix_hs  = s_pix_valid_i & s_pix_ready_o;
  assign skid_in = {(acc_cnt_q == burst_q - FRAME_BEATS_W'(1)), s_pix_data_i};

  axi_skid_buf #(
    .WIDTH (DMA_DATA_W + 1)
  ) u_w_skid (
    .clk         (clk),
    .rst         (rst),
    .in_data_i   (skid_in),
    .in_valid_i  (pix_hs),
    .in_ready_o  (skid_in_ready),
    .out_data_o  (skid_out),
    .out_valid_o (skid_out_valid),
    .out_ready_i (m_wready_i)
  );

  assign m_wdata_o  = skid_out[DMA_DATA_W-1:0];
  assign m_wlast_o  = skid_out_valid & skid_out[DMA_DATA_W];
  assign m_wvalid_o = skid_out_valid;
  assign w_hs       = skid_out_valid & m_wready_i;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Next-state and counter logic
  always_comb begin
    state_d         = state_q;
    remaining_d     = remaining_q;
    burst_d         = burst_q;
    acc_cnt_d       = acc_cnt_q;
    resp_err_d      = resp_err_q;
    frame_done_d    = 1'b0;
    remaining_after = remaining_q - burst_q;
    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          remaining_d = frame_beats_i;
          resp_err_d  = 1'b0;
          burst_d     = FRAME_BEATS_W'(burst_len(32'(frame_beats_i), MAX_BURST));
          if (frame_beats_i == '0) frame_done_d = 1'b1;
          else                     state_d      = ST_AW;
        end
      end
      ST_AW: begin
        if (m_awready_i) begin
          acc_cnt_d = '0;
          state_d   = ST_W;
        end
      end
      ST_W: begin
        if (pix_hs) acc_cnt_d = acc_cnt_q + FRAME_BEATS_W'(1);
        if (w_hs && skid_out[DMA_DATA_W]) state_d = ST_B;
      end
      ST_B: begin
        if (m_bvalid_i) begin
          if (m_bresp_i != TRANS_RESP_W'(AXI_RESP_OKAY)) resp_err_d = 1'b1;
          remaining_d = remaining_after;
          burst_d     = FRAME_BEATS_W'(burst_len(32'(remaining_after), MAX_BURST));
          if (remaining_after == '0) begin
            frame_done_d = 1'b1;
            state_d      = ST_IDLE;
          end else begin
            state_d = ST_AW;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      remaining_q  <= '0;
      burst_q      <= '0;
      acc_cnt_q    <= '0;
      resp_err_q   <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      remaining_q  <= remaining_d;
      burst_q      <= burst_d;
      acc_cnt_q    <= acc_cnt_d;
      resp_err_q   <= resp_err_d;
      frame_done_q <= frame_done_d;
    end
  end

  // Output logic
  always_comb begin
    busy_o        = (state_q != ST_IDLE);
    m_awvalid_o   = (state_q == ST_AW);
    m_awlen_o     = (state_q == ST_AW) ?
                    TRANS_DATA_LEN_W'(burst_q - FRAME_BEATS_W'(1)) : '0;
    m_bready_o    = (state_q == ST_B);
    s_pix_ready_o = (state_q == ST_W) && skid_in_ready && (acc_cnt_q < burst_q);
    frame_done_o  = frame_done_q;
    resp_err_o    = resp_err_q;
    m_awid_o      = MST_ID;
    m_awaddr_o    = IP_DATA_BASE_ADDR;
  end

endmodule

// File: tb/tb_dbi_frame_axi_writer.sv
module tb_dbi_frame_axi_writer;

  localparam int DW   = 256;
  localparam int AW   = 32;
  localparam int IDW  = 5;
  localparam int LW   = 8;
  localparam int RW   = 2;
  localparam int FBW  = 16;
  localparam int MAXB = 16;
  localparam logic [IDW-1:0] MST_ID = 5'h00;
  localparam logic [AW-1:0]  BASE   = 32'h2000_0000;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           start_i = 1'b0;
  logic [FBW-1:0] frame_beats_i = '0;
  logic           busy_o, frame_done_o, resp_err_o;
  logic [DW-1:0]  s_pix_data_i = '0;
  logic           s_pix_valid_i = 1'b0;
  logic           s_pix_ready_o;
  logic [IDW-1:0] m_awid_o;
  logic [AW-1:0]  m_awaddr_o;
  logic [LW-1:0]  m_awlen_o;
  logic           m_awvalid_o;
  logic           m_awready_i = 1'b0;
  logic [DW-1:0]  m_wdata_o;
  logic           m_wlast_o, m_wvalid_o;
  logic           m_wready_i = 1'b0;
  logic [IDW-1:0] m_bid_i = '0;
  logic [RW-1:0]  m_bresp_i = '0;
  logic           m_bvalid_i = 1'b0;
  logic           m_bready_o;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  dbi_frame_axi_writer #(
    .DMA_DATA_W        (DW),
    .ADDR_W            (AW),
    .MST_ID_W          (IDW),
    .TRANS_DATA_LEN_W  (LW),
    .TRANS_RESP_W      (RW),
    .MST_ID            (MST_ID),
    .IP_DATA_BASE_ADDR (BASE),
    .MAX_BURST         (MAXB),
    .FRAME_BEATS_W     (FBW)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .start_i       (start_i),
    .frame_beats_i (frame_beats_i),
    .busy_o        (busy_o),
    .frame_done_o  (frame_done_o),
    .resp_err_o    (resp_err_o),
    .s_pix_data_i  (s_pix_data_i),
    .s_pix_valid_i (s_pix_valid_i),
    .s_pix_ready_o (s_pix_ready_o),
    .m_awid_o      (m_awid_o),
    .m_awaddr_o    (m_awaddr_o),
    .m_awlen_o     (m_awlen_o),
    .m_awvalid_o   (m_awvalid_o),
    .m_awready_i   (m_awready_i),
    .m_wdata_o     (m_wdata_o),
    .m_wlast_o     (m_wlast_o),
    .m_wvalid_o    (m_wvalid_o),
    .m_wready_i    (m_wready_i),
    .m_bid_i       (m_bid_i),
    .m_bresp_i     (m_bresp_i),
    .m_bvalid_i    (m_bvalid_i),
    .m_bready_o    (m_bready_o)
  );

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  task automatic chki(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chkw(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] rand_word();
    logic [DW-1:0] w;
    for (int i = 0; i < DW / 32; i++) w[i*32 +: 32] = $urandom;
    return w;
  endfunction

  task automatic idle_checks(input string tag);
    chk1({tag, "_awvalid"}, m_awvalid_o, 1'b0);
    chk1({tag, "_wvalid"}, m_wvalid_o, 1'b0);
    chk1({tag, "_wlast"}, m_wlast_o, 1'b0);
    chk1({tag, "_bready"}, m_bready_o, 1'b0);
    chk1({tag, "_pix_ready"}, s_pix_ready_o, 1'b0);
    chk1({tag, "_busy"}, busy_o, 1'b0);
    chk1({tag, "_done"}, frame_done_o, 1'b0);
    chk1({tag, "_resp_err"}, resp_err_o, 1'b0);
    chki({tag, "_awlen"}, int'(m_awlen_o), 0);
    chki({tag, "_awid"}, int'(m_awid_o), int'(MST_ID));
    chki({tag, "_awaddr"}, int'(m_awaddr_o), int'(BASE));
  endtask

  // One frame against a transaction-level model: the frame is split into
  // chunks of at most MAXB beats, pixel words must come out in order, one
  // burst outstanding at a time.
  task automatic run_frame(input int n, input int rdy_pct, input int pv_pct,
                           input int bv_pct, input int err_idx,
                           input bit poke_start, input int abort_beat);
    int            bursts[$];
    logic [DW-1:0] src_q[$];
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] prev_wdata = '0;
    logic          prev_wlast = 1'b0;
    bit            prev_wstall = 1'b0;
    int  rem = n;
    int  bi = 0, phase, acc = 0, wbeats = 0, tot_w = 0, first_cyc = 0;
    int  cyc = 0, tail = 0;
    bit  exp_err = 1'b0, exp_done, exp_busy, allowed, aborted = 1'b0;
    bit  full_rate = (rdy_pct >= 100) && (pv_pct >= 100);

    while (rem > 0) begin
      bursts.push_back((rem > MAXB) ? MAXB : rem);
      rem -= bursts[$];
    end

    @(negedge clk);
    start_i       = 1'b1;
    frame_beats_i = FBW'(n);
    exp_done      = (n == 0);
    exp_busy      = (n != 0);
    phase         = (n == 0) ? 3 : 0;
    if (n == 0) tail = 2;

    while (1) begin
      @(negedge clk);
      cyc++;
      // Outputs reflect every handshake up to the previous rising edge.
      chk1("busy", busy_o, exp_busy);
      chk1("frame_done", frame_done_o, exp_done);
      chk1("resp_err", resp_err_o, exp_err);
      chk1("awvalid", m_awvalid_o, phase == 0);
      chk1("bready", m_bready_o, phase == 2);
      chk1("wvalid_outside_burst", m_wvalid_o & (phase != 1), 1'b0);
      chki("awid", int'(m_awid_o), int'(MST_ID));
      chki("awaddr", int'(m_awaddr_o), int'(BASE));
      if (m_awvalid_o && bi < bursts.size())
        chki("awlen", int'(m_awlen_o), bursts[bi] - 1);
      allowed = (phase == 1) && (bi < bursts.size()) && (acc < bursts[bi]);
      chk1("pix_ready_bound", s_pix_ready_o & ~allowed, 1'b0);
      if (prev_wstall) begin
        chk1("w_hold_valid", m_wvalid_o, 1'b1);
        chkw("w_hold_data", m_wdata_o, prev_wdata);
        chk1("w_hold_last", m_wlast_o, prev_wlast);
      end
      exp_done = 1'b0;

      if (tail > 0) begin
        tail--;
        if (tail == 0) break;
      end
      if (cyc >= 3000) begin
        checks++;
        failures++;
        $error("FAIL frame_timeout observed=%0d cycles expected=completion", cyc);
        break;
      end

      // Drive this cycle's inputs.
      start_i       = poke_start && (phase == 1) && ($urandom_range(0, 7) == 0);
      frame_beats_i = start_i ? FBW'(3) : '0;
      if (src_q.size() == 0) src_q.push_back(rand_word());
      s_pix_data_i  = src_q[0];
      s_pix_valid_i = ($urandom_range(0, 99) < pv_pct);
      m_awready_i   = ($urandom_range(0, 99) < rdy_pct);
      m_wready_i    = ($urandom_range(0, 99) < rdy_pct);
      m_bvalid_i    = (phase == 2) && ($urandom_range(0, 99) < bv_pct);
      m_bresp_i     = (bi == err_idx) ? 2'b10 : 2'b00;
      m_bid_i       = IDW'($urandom);

      prev_wstall = m_wvalid_o && !m_wready_i;
      prev_wdata  = m_wdata_o;
      prev_wlast  = m_wlast_o;

      // Handshakes completing at the coming rising edge.
      if (s_pix_valid_i && s_pix_ready_o) begin
        exp_q.push_back(src_q.pop_front());
        acc++;
      end
      if (m_wvalid_o && m_wready_i && phase == 1) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $error("FAIL w_extra_beat observed=%0h expected=none", m_wdata_o);
        end else begin
          chkw("wdata", m_wdata_o, exp_q.pop_front());
        end
        chk1("wlast", m_wlast_o, wbeats == bursts[bi] - 1);
        if (wbeats == 0) first_cyc = cyc;
        wbeats++;
        tot_w++;
        if (wbeats == bursts[bi]) begin
          if (full_rate) chki("w_consecutive", cyc - first_cyc, bursts[bi] - 1);
          phase = 2;
        end
      end
      if (m_awvalid_o && m_awready_i) begin
        phase  = 1;
        acc    = 0;
        wbeats = 0;
      end
      if (m_bready_o && m_bvalid_i) begin
        if (m_bresp_i != 2'b00) exp_err = 1'b1;
        bi++;
        if (bi == bursts.size()) begin
          phase    = 3;
          exp_done = 1'b1;
          exp_busy = 1'b0;
          tail     = 2;
        end else begin
          phase = 0;
        end
      end

      if (abort_beat != 0 && tot_w == abort_beat) begin
        rst           = 1'b1;
        s_pix_valid_i = 1'b0;
        m_wready_i    = 1'b0;
        m_awready_i   = 1'b0;
        aborted       = 1'b1;
        break;
      end
    end

    start_i       = 1'b0;
    s_pix_valid_i = 1'b0;
    m_bvalid_i    = 1'b0;
    if (aborted) begin
      @(negedge clk);
      idle_checks("after_reset");
      rst = 1'b0;
    end else if (exp_q.size() != 0) begin
      checks++;
      failures++;
      $error("FAIL beats_left observed=%0d expected=0", exp_q.size());
    end
  endtask

  initial begin
    rst = 1'b1;
    repeat (3) @(negedge clk);
    idle_checks("reset");
    rst = 1'b0;

    run_frame(16, 100, 100, 100, -1, 1'b0, 0);
    run_frame(40, 100, 100, 100, -1, 1'b0, 0);
    run_frame(40, 60, 70, 50, -1, 1'b1, 0);
    run_frame(40, 80, 80, 60, 1, 1'b0, 0);
    run_frame(24, 100, 100, 100, -1, 1'b0, 0);
    run_frame(0, 100, 100, 100, -1, 1'b0, 0);
    run_frame(16, 100, 100, 100, -1, 1'b0, 5);
    run_frame(16, 100, 100, 100, -1, 1'b0, 0);
    for (int k = 0; k < 4; k++)
      run_frame(int'($urandom_range(1, 70)), int'($urandom_range(40, 100)),
                int'($urandom_range(40, 100)), int'($urandom_range(30, 100)),
                int'($urandom_range(0, 5)), 1'b1, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dbi_frame_axi_writer.md
Name: dbi_frame_axi_writer

Overview:
- Upstream feeder for dbi_tx_controller's DMA data slave port.
- Accepts a stream of 256-bit pixel words from the frame source.
- Packs the words into AXI4 write bursts aimed at IP_DATA_BASE_ADDR.
- Tracks frame progress and reports completion and slave error responses to the frame sequencer.

Parameters:
- DMA_DATA_W, 256, pixel word / AXI W data width
- ADDR_W, 32, AXI address width
- MST_ID_W, 5, AXI ID width
- TRANS_DATA_LEN_W, 8, AWLEN width
- TRANS_RESP_W, 2, BRESP width
- MST_ID, 5'h00, constant AWID driven on every burst
- IP_DATA_BASE_ADDR, 32'h2000_0000, constant AWADDR (controller data window is address-invariant)
- MAX_BURST, 16, maximum beats per burst (1..256)
- FRAME_BEATS_W, 16, width of frame beat count

Ports:
- clk  in  1  sole clock
- rst  in  1  synchronous active-high reset
- start_i  in  1  start-frame pulse
- frame_beats_i  in  FRAME_BEATS_W  beats in frame; sampled on accepted start
- busy_o  out  1  frame in progress
- frame_done_o  out  1  one-cycle pulse at frame end
- resp_err_o  out  1  sticky non-OKAY BRESP seen
- s_pix_data_i  in  DMA_DATA_W  pixel word
- s_pix_valid_i  in  1  pixel word valid
- s_pix_ready_o  out  1  pixel word accepted
- m_awid_o  out  MST_ID_W  write ID
- m_awaddr_o  out  ADDR_W  write address
- m_awlen_o  out  TRANS_DATA_LEN_W  beats-1
- m_awvalid_o  out  1  AW valid
- m_awready_i  in  1  AW ready
- m_wdata_o  out  DMA_DATA_W  W data
- m_wlast_o  out  1  last beat of burst
- m_wvalid_o  out  1  W valid
- m_wready_i  in  1  W ready
- m_bid_i  in  MST_ID_W  response ID (ignored)
- m_bresp_i  in  TRANS_RESP_W  response code
- m_bvalid_i  in  1  B valid
- m_bready_o  out  1  B ready

Behaviour:
- Reset: all outputs 0, except m_awid_o=MST_ID and m_awaddr_o=IP_DATA_BASE_ADDR (constants). FSM goes to IDLE, counters clear, resp_err_o clears, skid buffer empties.
- Reset mid-burst abandons the burst silently; no wlast, no B wait.
- FSM states: IDLE, AW, W, B.
- IDLE:
  - start_i=1 latches remaining=frame_beats_i and clears resp_err_o.
  - If frame_beats_i=0: frame_done_o pulses next cycle and FSM stays in IDLE.
  - Otherwise go to AW.
  - start_i is ignored outside IDLE.
- busy_o = (state != IDLE).
- AW:
  - burst = min(remaining, MAX_BURST); m_awlen_o = burst-1, held stable.
  - m_awvalid_o=1 until m_awready_i; must not drop before handshake.
  - On handshake: beat_cnt=0, go to W.
- W:
  - W data path is a 2-entry skid buffer.
  - s_pix_ready_o=1 only in W, while buffer not full and accepted-beat count < burst.
  - Accepted word appears on m_wdata_o no earlier than the next cycle (1-cycle min latency).
  - Full-throughput: 1 beat/cycle when s_pix_valid_i and m_wready_i are both held high.
  - m_wvalid_o/m_wdata_o/m_wlast_o are stable from assertion until m_wready_i.
  - m_wlast_o=1 exactly on beat burst-1.
  - After the wlast handshake: go to B.
  - No pixel words are accepted beyond the current burst's count.
- B:
  - m_bready_o=1.
  - On m_bvalid_i: if m_bresp_i != 2'b00, set resp_err_o=1 (sticky until next start or rst). Then remaining -= burst.
  - If remaining=0: frame_done_o=1 for one cycle, go to IDLE. Otherwise go to AW.
  - Error does not abort the frame.
- Single outstanding transaction: the next AW is issued only after the prior B.
- Counters are FRAME_BEATS_W wide with no wrap; remaining never underflows (burst ≤ remaining).
- Simultaneous wvalid/wready on the last beat in the same cycle the skid buffer refills: the next pixel is not accepted.

Decomposition:
- Package dbi_frame_writer_pkg:
  - FSM state enum
  - AXI_RESP_OKAY=2'b00
  - burst length function (min remaining/MAX_BURST)
- Sub-module axi_skid_buf: parameterised width, 2-entry valid/ready register slice. Instantiated once on the W path (data+last).

Test Plan:
- Frame 16 beats, MAX_BURST=16, all ready high -> one AW with awlen=15; 16 W beats in 16 consecutive cycles with data in order; wlast on beat 16; B OKAY -> frame_done_o one pulse; resp_err_o=0.
- Frame 40 beats -> three bursts with awlen 15, 15, 7; wlast on beats 16, 32, 40; each AW only after preceding B; single frame_done_o.
- Random m_wready_i/s_pix_valid_i throttling on a 40-beat frame -> W payload stable while stalled; no beat lost or duplicated; s_pix_ready_o low after each burst's last beat until the next AW handshake.
- BRESP=2'b10 on the 2nd of 3 bursts -> resp_err_o=1 from that cycle; 3rd burst still issued; frame_done_o pulses; next start_i clears resp_err_o.
- start_i with frame_beats_i=0 -> no AW; frame_done_o pulse 1 cycle later; busy_o stays 0. start_i while busy -> ignored.
- rst asserted mid-burst (after beat 5 of 16) -> next cycle all valids 0, busy_o=0; a new 16-beat frame then completes normally.
